// File: rtl/mag_pkg.sv
// Shared encodings, LFSR constants and the relation-mapping helper for mag_pair_gen.
package mag_pkg;

    localparam logic [1:0] REL_GT  = 2'b00;
    localparam logic [1:0] REL_LT  = 2'b01;
    localparam logic [1:0] REL_EQ  = 2'b10;
    localparam logic [1:0] REL_ANY = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_GEN     = 2'b01,
        ST_PRESENT = 2'b10,
        ST_DONE    = 2'b11
    } state_t;

    // Feedback taps q[7], q[5], q[4], q[3]
    localparam logic [7:0] LFSR_TAPS    = 8'hB8;
    localparam logic [7:0] DEFAULT_SEED = 8'hA5;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic       gt;
        logic       lt;
        logic       eq;
    } pair_t;

    localparam pair_t PAIR_RESET = '{a: 4'd0, b: 4'd0, gt: 1'b0, lt: 1'b0, eq: 1'b1};

    // Forces the raw candidate into the requested relation; flags follow the final pair.
    function automatic pair_t map_pair(input logic [1:0] rel, input logic [7:0] cand);
        logic [3:0] ca;
        logic [3:0] cb;
        pair_t      p;
        ca = cand[7:4];
        cb = cand[3:0];
        p  = PAIR_RESET;
        p.a = ca;
        p.b = cb;
        case (rel)
            REL_GT: begin
                if (ca > cb)          begin p.a = ca;   p.b = cb;         end
                else if (ca < cb)     begin p.a = cb;   p.b = ca;         end
                else if (ca != 4'd0)  begin p.a = ca;   p.b = ca - 4'd1;  end
                else                  begin p.a = 4'd1; p.b = 4'd0;       end
            end
            REL_LT: begin
                if (ca < cb)          begin p.a = ca;         p.b = cb;   end
                else if (ca > cb)     begin p.a = cb;         p.b = ca;   end
                else if (ca != 4'd0)  begin p.a = ca - 4'd1;  p.b = ca;   end
                else                  begin p.a = 4'd0;       p.b = 4'd1; end
            end
            REL_EQ: begin
                p.a = ca;
                p.b = ca;
            end
            default: begin
                p.a = ca;
                p.b = cb;
            end
        endcase
        p.gt = (p.a > p.b);
        p.lt = (p.a < p.b);
        p.eq = (p.a == p.b);
        return p;
    endfunction

endpackage

// File: rtl/mag_lfsr8.sv
// 8-bit left-shifting Fibonacci LFSR with synchronous load and step enable.
module mag_lfsr8
    import mag_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] seed,
    input  logic       step,
    output logic [7:0] q
);

    logic [7:0] r_q;

    always_ff @(posedge clk) begin
        if (rst)
            r_q <= DEFAULT_SEED;
        else if (load)
            r_q <= seed;
        else if (step)
            r_q <= {r_q[6:0], ^(r_q & LFSR_TAPS)};
    end

    assign q = r_q;

endmodule

// File: rtl/mag_pair_gen.sv
// Generates operand pairs in a requested magnitude relation with expected comparator flags.
// Optional result checker enabled by defining MAG_PAIR_CHECK_EN.
module mag_pair_gen
    import mag_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] rel_sel,
    input  logic [7:0] num_pairs,
    input  logic [7:0] seed,
    input  logic       ready,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic       valid,
    output logic       exp_gt,
    output logic       exp_lt,
    output logic       exp_eq,
    output logic       busy,
    output logic       done
`ifdef MAG_PAIR_CHECK_EN
    ,
    input  logic       res_gt,
    input  logic       res_lt,
    input  logic       res_eq,
    output logic [7:0] err_cnt,
    output logic       mismatch
`endif
);

    // state   | meaning
    // IDLE    | waiting for start, last pair held on A/B
    // GEN     | map LFSR candidate into A/B, advance LFSR
    // PRESENT | pair valid, waiting for ready
    // DONE    | one-cycle done pulse

    state_t     r_state;
    state_t     w_state_next;
    logic       w_accept_start;
    logic       w_gen;
    logic       w_hs;
    logic [7:0] w_seed_eff;
    logic [7:0] w_lfsr_q;
    logic [7:0] w_count_next;

    logic [1:0] r_rel;
    logic [7:0] r_num_pairs;
    logic [7:0] r_count;
    pair_t      r_pair;
    logic       r_valid;

    assign w_seed_eff   = (seed == 8'd0) ? DEFAULT_SEED : seed;
    assign w_count_next = r_count + 8'd1;

    mag_lfsr8 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (w_accept_start),
        .seed (w_seed_eff),
        .step (w_gen),
        .q    (w_lfsr_q)
    );

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next   = r_state;
        w_accept_start = 1'b0;
        w_gen          = 1'b0;
        w_hs           = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept_start = 1'b1;
                    w_state_next   = (num_pairs == 8'd0) ? ST_DONE : ST_GEN;
                end
            end
            ST_GEN: begin
                w_gen        = 1'b1;
                w_state_next = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (r_valid && ready) begin
                    w_hs         = 1'b1;
                    w_state_next = (w_count_next == r_num_pairs) ? ST_DONE : ST_GEN;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Run parameters are captured only on an accepted start, so mid-run input changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rel       <= REL_GT;
            r_num_pairs <= 8'd0;
            r_count     <= 8'd0;
            r_pair      <= PAIR_RESET;
            r_valid     <= 1'b0;
        end else begin
            if (w_accept_start) begin
                r_rel       <= rel_sel;
                r_num_pairs <= num_pairs;
                r_count     <= 8'd0;
            end
            if (w_gen) begin
                r_pair  <= map_pair(r_rel, w_lfsr_q);
                r_valid <= 1'b1;
            end
            if (w_hs) begin
                r_count <= w_count_next;
                r_valid <= 1'b0;
            end
        end
    end

    assign A      = r_pair.a;
    assign B      = r_pair.b;
    assign exp_gt = r_pair.gt;
    assign exp_lt = r_pair.lt;
    assign exp_eq = r_pair.eq;
    assign valid  = r_valid;
    assign busy   = (r_state != ST_IDLE);
    assign done   = (r_state == ST_DONE);

`ifdef MAG_PAIR_CHECK_EN
    logic [7:0] r_err_cnt;
    logic       r_mismatch;

    always_ff @(posedge clk) begin
        if (rst || w_accept_start) begin
            r_err_cnt  <= 8'd0;
            r_mismatch <= 1'b0;
        end else if (w_hs && ({res_gt, res_lt, res_eq} != {r_pair.gt, r_pair.lt, r_pair.eq})) begin
            if (r_err_cnt != 8'hFF)
                r_err_cnt <= r_err_cnt + 8'd1;
            r_mismatch <= 1'b1;
        end
    end

    assign err_cnt  = r_err_cnt;
    assign mismatch = r_mismatch;
`endif

endmodule
